// File: rtl/axi_lite_mem_slave.sv
`default_nettype none
// ============================================================================
// axi_lite_mem_slave -- AXI-lite responder over a byte-strobed word RAM.
// Rev 1.0 -- independent read/write FSMs, SLVERR on out-of-range accesses.
// ============================================================================
module axi_lite_mem_slave #(
  parameter int                    ADDR_WIDTH   = 64,
  parameter int                    DATA_WIDTH   = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    DEPTH        = 4096,
  parameter int                    READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int         c_strb_w = DATA_WIDTH / 8;
  localparam int         c_offs   = $clog2(c_strb_w);
  localparam int         c_idx_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] c_lat_m1 = 4'(READ_LATENCY - 1);
  localparam logic [1:0] c_okay   = 2'b00;
  localparam logic [1:0] c_slverr = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_COMMIT = 2'd1,
    W_RESP   = 2'd2
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } rstate_e;

  // Offset subtraction wraps at ADDR_WIDTH, so the >= BASE_ADDR test is needed too.
  function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> c_offs) < ADDR_WIDTH'(DEPTH));
  endfunction

  function automatic logic [c_idx_w-1:0] f_index(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return c_idx_w'(off >> c_offs);
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // ---------------------------------------------------------------- write side
  wstate_e               r_wstate;
  wstate_e               w_wstate_nxt;
  logic                  r_aw_lat;
  logic                  r_w_lat;
  logic                  w_aw_lat_nxt;
  logic                  w_w_lat_nxt;
  logic                  r_awready;
  logic                  r_wready;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [c_strb_w-1:0]   r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  w_wr_ok;
  logic [c_idx_w-1:0]    w_wr_idx;

  assign w_aw_hs  = awvalid && r_awready;
  assign w_w_hs   = wvalid && r_wready;
  assign w_wr_ok  = f_in_range(r_awaddr);
  assign w_wr_idx = f_index(r_awaddr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wstate <= W_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_aw_lat_nxt = r_aw_lat;
    w_w_lat_nxt  = r_w_lat;
    w_commit     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_aw_lat_nxt = r_aw_lat | w_aw_hs;
        w_w_lat_nxt  = r_w_lat | w_w_hs;
        if (w_aw_lat_nxt && w_w_lat_nxt) begin
          w_wstate_nxt = W_COMMIT;
        end
      end
      W_COMMIT: begin
        w_commit     = 1'b1;
        w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        if (bready) begin
          w_wstate_nxt = W_IDLE;
          w_aw_lat_nxt = 1'b0;
          w_w_lat_nxt  = 1'b0;
        end
      end
      default: begin
        w_wstate_nxt = W_IDLE;
        w_aw_lat_nxt = 1'b0;
        w_w_lat_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_aw_lat  <= 1'b0;
      r_w_lat   <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= c_okay;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_aw_lat  <= w_aw_lat_nxt;
      r_w_lat   <= w_w_lat_nxt;
      r_awready <= (w_wstate_nxt == W_IDLE) && !w_aw_lat_nxt;
      r_wready  <= (w_wstate_nxt == W_IDLE) && !w_w_lat_nxt;
      r_bvalid  <= (w_wstate_nxt == W_RESP);
      if (w_commit) begin
        r_bresp <= w_wr_ok ? c_okay : c_slverr;
      end
      if (w_aw_hs) begin
        r_awaddr <= awaddr;
      end
      if (w_w_hs) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
    end
  end

  // RAM contents survive reset; only the commit state can write them.
  always_ff @(posedge clk) begin
    if (w_commit && w_wr_ok) begin
      for (int b = 0; b < c_strb_w; b++) begin
        if (r_wstrb[b]) begin
          r_mem[w_wr_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

  // ----------------------------------------------------------------- read side
  rstate_e               r_rstate;
  rstate_e               w_rstate_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic                  w_ar_hs;
  logic                  w_rload;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  w_rd_ok;
  logic [c_idx_w-1:0]    w_rd_idx;

  assign w_ar_hs  = arvalid && r_arready;
  assign w_rd_ok  = f_in_range(r_araddr);
  assign w_rd_idx = f_index(r_araddr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rstate <= R_IDLE;
    end else begin
      r_rstate <= w_rstate_nxt;
    end
  end

  // R_WAIT always lasts READ_LATENCY cycles, so rvalid rises READ_LATENCY edges after AR.
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_cnt_nxt    = r_cnt;
    w_rload      = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) begin
          w_rstate_nxt = R_WAIT;
          w_cnt_nxt    = c_lat_m1;
        end
      end
      R_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_rstate_nxt = R_DATA;
          w_rload      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      R_DATA: begin
        if (rready) begin
          w_rstate_nxt = R_IDLE;
        end
      end
      default: begin
        w_rstate_nxt = R_IDLE;
      end
    endcase
  end

  // The RAM read uses the pre-edge contents, giving read-before-write on a collision.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt     <= 4'd0;
      r_araddr  <= '0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= c_okay;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_rvalid  <= (w_rstate_nxt == R_DATA);
      if (w_ar_hs) begin
        r_araddr <= araddr;
      end
      if (w_rload) begin
        r_rdata <= w_rd_ok ? r_mem[w_rd_idx] : '0;
        r_rresp <= w_rd_ok ? c_okay : c_slverr;
      end
    end
  end

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

endmodule
`default_nettype wire
